display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It drives the 3-bit nibble select of the display datapath and the active-low anode and segment lines. It snapshots a 16-bit value once per frame so the display never tears, and supports optional leading-zero suppression and per-digit decimal points. It sits between the value-producing logic and the board display pins.

---
 rtl/display_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-frame snapshot of the value, anti-ghosting
// blank window per slot, optional leading-zero suppression and per-digit decimal points.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned BLANK    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [2:0]  sel,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] CntMax   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK);

  logic [CntW-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic            shadow_lz_q, shadow_lz_d;
  logic [2:0]      sel_q, sel_d;
  logic [3:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d;
  logic            frame_tick_q, frame_tick_d;

  logic            slot_wrap;
  logic            frame_wrap;
  logic [3:0]      nib;
  logic            blank_dig;
  logic [6:0]      seg_raw;

  assign slot_wrap  = (pre_cnt_q == CntMax);
  assign frame_wrap = slot_wrap && (digit_q == 2'd3);

  // Scan counters and frame snapshot
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    digit_d      = digit_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_lz_d  = shadow_lz_q;
    frame_tick_d = 1'b0;
    if (!enable) begin
      pre_cnt_d   = '0;
      digit_d     = 2'd0;
      shadow_d    = data_in;
      shadow_dp_d = dp_in;
      shadow_lz_d = lz_en;
    end else if (slot_wrap) begin
      pre_cnt_d = '0;
      digit_d   = digit_q + 2'd1;
      if (frame_wrap) begin
        shadow_d     = data_in;
        shadow_dp_d  = dp_in;
        shadow_lz_d  = lz_en;
        frame_tick_d = 1'b1;
      end
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Output decode from the current state; registered below for one cycle of latency
  always_comb begin
    nib       = 4'h0;
    blank_dig = 1'b0;
    unique case (digit_q)
      2'd0: nib = shadow_q[3:0];
      2'd1: begin
        nib       = shadow_q[7:4];
        blank_dig = (shadow_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib       = shadow_q[11:8];
        blank_dig = (shadow_q[15:8] == 8'h00);
      end
      2'd3: begin
        nib       = shadow_q[15:12];
        blank_dig = (shadow_q[15:12] == 4'h0);
      end
    endcase
    blank_dig = blank_dig & shadow_lz_q;

    case (nib)
      4'h0: seg_raw = 7'b1000000;
      4'h1: seg_raw = 7'b1111001;
      4'h2: seg_raw = 7'b0100100;
      4'h3: seg_raw = 7'b0110000;
      4'h4: seg_raw = 7'b0011001;
      4'h5: seg_raw = 7'b0010010;
      4'h6: seg_raw = 7'b0000010;
      4'h7: seg_raw = 7'b1111000;
      4'h8: seg_raw = 7'b0000000;
      4'h9: seg_raw = 7'b0010000;
      4'hA: seg_raw = 7'b0001000;
      4'hB: seg_raw = 7'b0000011;
      4'hC: seg_raw = 7'b1000110;
      4'hD: seg_raw = 7'b0100001;
      4'hE: seg_raw = 7'b0000110;
      default: seg_raw = 7'b0001110;
    endcase

    seg_n_d = blank_dig ? 7'h7F : seg_raw;
    dp_n_d  = blank_dig | ~shadow_dp_q[digit_q];
    sel_d   = enable ? {1'b0, digit_q} : 3'b000;
    an_n_d  = (!enable || (pre_cnt_q < BlankCnt)) ? 4'hF : ~(4'b0001 << digit_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q    <= '0;
      digit_q      <= 2'd0;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      shadow_lz_q  <= 1'b0;
      sel_q        <= 3'b000;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lz_q  <= shadow_lz_d;
      sel_q        <= sel_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: timeline reference model feeds a scoreboard queue that a
// negedge monitor drains against the registered outputs.
module tb_display_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
    7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
    7'b0000110, 7'b0001110};

  typedef struct {
    int         cyc;
    logic [2:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [2:0]  sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  // Reference model: position on the frame timeline plus the displayed snapshot
  int          m_t;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic        m_lz;

  display_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .sel        (sel),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sel", 16'(sel), 16'(e.sel));
      chk("an_n", 16'(an_n), 16'(e.an));
      chk("seg_n", 16'(seg_n), 16'(e.seg));
      chk("dp_n", 16'(dp_n), 16'(e.dp));
      chk("frame_tick", 16'(frame_tick), 16'(e.tick));
    end
  end

  task automatic model_reset();
    m_t  = 0;
    m_sh = 16'h0000;
    m_dp = 4'h0;
    m_lz = 1'b0;
  endtask

  // Apply inputs for the coming edge, predict what that edge registers, advance the model
  task automatic step(input logic en, input logic [15:0] d, input logic [3:0] dp,
                      input logic lz);
    exp_t e;
    int   pos, dig;
    logic blanked;
    enable  = en;
    data_in = d;
    dp_in   = dp;
    lz_en   = lz;
    pos     = m_t % P;
    dig     = (m_t / P) % 4;
    blanked = m_lz && dig != 0 && ((m_sh >> (4 * dig)) == 16'h0000);
    e.cyc   = cyc + 1;
    e.sel   = en ? 3'(dig) : 3'b000;
    e.an    = (!en || pos < B) ? 4'hF : ~(4'b0001 << dig);
    e.seg   = blanked ? 7'h7F : HEX[(m_sh >> (4 * dig)) & 16'hF];
    e.dp    = blanked ? 1'b1 : ~m_dp[dig];
    e.tick  = en && (m_t == FRAME - 1);
    sb_q.push_back(e);
    if (!en) begin
      m_t  = 0;
      m_sh = d;
      m_dp = dp;
      m_lz = lz;
    end else begin
      m_t = m_t + 1;
      if (m_t == FRAME) begin
        m_t  = 0;
        m_sh = d;
        m_dp = dp;
        m_lz = lz;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [15:0] d, input logic [3:0] dp, input logic lz);
    for (int i = 0; i < n; i++) step(1'b1, d, dp, lz);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an_n"}, 16'(an_n), 16'hF);
    chk({tag, "_seg_n"}, 16'(seg_n), 16'h7F);
    chk({tag, "_dp_n"}, 16'(dp_n), 16'h1);
    chk({tag, "_sel"}, 16'(sel), 16'h0);
    chk({tag, "_tick"}, 16'(frame_tick), 16'h0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdp;
    logic        rlz;
    logic        ren;
    #2 reset_n = 1'b0;
    #1 check_dark("reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // First frame after reset shows the zero snapshot, then 0x12A4
    run(2 * FRAME + 8, 16'h12A4, 4'h0, 1'b0);
    // Mid-frame changes are deferred to the next frame
    run(FRAME + 5, 16'h1234, 4'h0, 1'b0);
    run(2 * FRAME, 16'hBEEF, 4'h0, 1'b0);
    // Leading zeros and decimal points
    run(2 * FRAME, 16'h0040, 4'h0, 1'b1);
    run(2 * FRAME, 16'h0000, 4'b0100, 1'b1);
    run(2 * FRAME, 16'h0000, 4'b0100, 1'b0);
    run(2 * FRAME, 16'h0301, 4'b1011, 1'b1);

    // Enable drop mid-slot, then re-enable without an initial frame tick
    run(P + 4, 16'h5678, 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h9A00 + 16'(i), 4'h2, 1'b1);
    run(2 * FRAME + 3, 16'h4321, 4'h0, 1'b0);

    // Disable landing exactly on the frame wrap edge
    while (m_t != FRAME - 1) step(1'b1, 16'hC0DE, 4'h0, 1'b0);
    step(1'b0, 16'hFACE, 4'h8, 1'b0);
    run(FRAME + 4, 16'h0007, 4'h0, 1'b1);

    // Randomised traffic
    rd = 16'h0;
    rdp = 4'h0;
    rlz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rd  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        rdp = 4'($urandom);
        rlz = 1'($urandom);
      end
      ren = ($urandom_range(0, 39) != 0);
      step(ren, rd, rdp, rlz);
    end

    // Asynchronous reset while a digit is lit
    while ((m_t % P) != B + 3) step(1'b1, 16'h8888, 4'hF, 1'b0);
    drain();
    chk("pre_reset_lit", 16'(an_n == 4'hF), 16'h0);
    reset_n = 1'b0;
    #1 check_dark("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run(FRAME + 6, 16'h2468, 4'h0, 1'b0);
    drain();

    chk("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
